// File: rtl/uart_rcv.sv
// 8N1 UART receiver: synchronises RX, rejects false start bits, samples every bit
// at its midpoint and presents the byte with a ready flag and a framing-error flag.
module uart_rcv #(
  parameter int unsigned BAUD_CYC = 2604,
  parameter int unsigned HALF_CYC = 1302
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   baud_cnt, nxt_baud;
  logic [BIT_W-1:0]   bit_cnt, nxt_bit;
  logic [7:0]         shft, nxt_shft;
  logic [7:0]         nxt_data;
  logic               nxt_rdy, nxt_frm;
  logic               rx_m, rx_s, rx_q;
  logic               fall;

  // Synchroniser plus edge-detect flop; preset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shft     <= '0;
      rx_data  <= 8'h00;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= nxt_state;
      baud_cnt <= nxt_baud;
      bit_cnt  <= nxt_bit;
      shft     <= nxt_shft;
      rx_data  <= nxt_data;
      rdy      <= nxt_rdy;
      frm_err  <= nxt_frm;
    end
  end

  // Next-state and datapath; a rdy set later in this block overrides clr_rdy.
  always_comb begin
    nxt_state = state;
    nxt_baud  = baud_cnt;
    nxt_bit   = bit_cnt;
    nxt_shft  = shft;
    nxt_data  = rx_data;
    nxt_rdy   = clr_rdy ? 1'b0 : rdy;
    nxt_frm   = frm_err;

    case (state)
      IDLE: begin
        if (fall) begin
          nxt_baud  = CNT_W'(HALF_CYC - 1);
          nxt_rdy   = 1'b0;
          nxt_state = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          if (rx_s) begin
            nxt_state = IDLE;
          end else begin
            nxt_baud  = CNT_W'(BAUD_CYC - 1);
            nxt_bit   = '0;
            nxt_frm   = 1'b0;
            nxt_state = DATA;
          end
        end else begin
          nxt_baud = baud_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          nxt_shft = {rx_s, shft[7:1]};
          nxt_bit  = bit_cnt + BIT_W'(1);
          nxt_baud = CNT_W'(BAUD_CYC - 1);
          if (bit_cnt == BIT_W'(7)) nxt_state = STOP;
        end else begin
          nxt_baud = baud_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          nxt_data  = shft;
          nxt_state = IDLE;
          if (rx_s) begin
            nxt_rdy = 1'b1;
            nxt_frm = 1'b0;
          end else begin
            nxt_frm = 1'b1;
          end
        end else begin
          nxt_baud = baud_cnt - CNT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule
